// File: rtl/pc_target_table.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_table
// Function : Banked next-PC target table, absolute or PC-relative entries,
//            1-cycle lookup, per-bank background sweep clear.
// Revision : 1.0
// ============================================================================
module pc_target_table #(
   parameter int D     = 12,
   parameter int A     = 5,
   parameter int BANKS = 2,
   localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [BW-1:0] rd_bank,
   input  logic [A-1:0]  rd_addr,
   input  logic [D-1:0]  rd_pc,
   output logic          rd_valid,
   output logic          rd_hit,
   output logic [D-1:0]  rd_target,
   input  logic          wr_en,
   input  logic [BW-1:0] wr_bank,
   input  logic [A-1:0]  wr_addr,
   input  logic          wr_rel,
   input  logic [D-1:0]  wr_data,
   input  logic          clear_req,
   input  logic [BW-1:0] clear_bank,
   output logic          clear_busy,
   output logic          clear_done
);

   localparam int         ENTRIES  = 2**A;
   localparam logic [A:0] LAST_IDX = (A+1)'(ENTRIES - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t        state_q;
   logic [A:0]    cnt_q;
   logic [BW-1:0] sbank_q;
   logic          clear_busy_q;
   logic          clear_done_q;

   logic [ENTRIES-1:0] valid_q [BANKS];
   logic [ENTRIES-1:0] rel_q   [BANKS];
   logic [D-1:0]       value_q [BANKS][ENTRIES];

   logic          rd_valid_q;
   logic          rd_hit_q;
   logic [D-1:0]  rd_target_q;

   logic          wr_ok_d;
   logic          rd_bank_ok_d;
   logic          rd_swept_d;
   logic          ent_v_d;
   logic          ent_rel_d;
   logic [D-1:0]  ent_val_d;
   logic          hit_d;
   logic [D-1:0]  target_d;

   // The bank under sweep is frozen against writes so the sweep result is final.
   assign wr_ok_d = wr_en && (32'(wr_bank) < BANKS)
                    && !(clear_busy_q && (wr_bank == sbank_q));

   always_comb begin
      ent_v_d      = 1'b0;
      ent_rel_d    = 1'b0;
      ent_val_d    = '0;
      rd_bank_ok_d = (32'(rd_bank) < BANKS);
      rd_swept_d   = clear_busy_q && (rd_bank == sbank_q);
      if (rd_bank_ok_d) begin
         ent_v_d   = valid_q[rd_bank][rd_addr];
         ent_rel_d = rel_q[rd_bank][rd_addr];
         ent_val_d = value_q[rd_bank][rd_addr];
      end
      // Write-first bypass for a same-cycle write to the looked-up entry.
      if (wr_ok_d && (wr_bank == rd_bank) && (wr_addr == rd_addr)) begin
         ent_v_d   = 1'b1;
         ent_rel_d = wr_rel;
         ent_val_d = wr_data;
      end
      hit_d    = rd_bank_ok_d && !rd_swept_d && ent_v_d;
      target_d = ent_rel_d ? (rd_pc + ent_val_d) : ent_val_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q  <= 1'b0;
         rd_hit_q    <= 1'b0;
         rd_target_q <= '0;
      end else begin
         rd_valid_q  <= rd_en;
         rd_hit_q    <= rd_en && hit_d;
         rd_target_q <= (rd_en && hit_d) ? target_d : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < BANKS; b++) begin
            valid_q[b] <= '0;
         end
      end else begin
         if (wr_ok_d) begin
            valid_q[wr_bank][wr_addr] <= 1'b1;
         end
         if (clear_busy_q) begin
            valid_q[sbank_q][cnt_q[A-1:0]] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok_d) begin
         rel_q[wr_bank][wr_addr]   <= wr_rel;
         value_q[wr_bank][wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sbank_q      <= '0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         clear_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (clear_req && (32'(clear_bank) < BANKS)) begin
                  state_q      <= ST_SWEEP;
                  sbank_q      <= clear_bank;
                  cnt_q        <= '0;
                  clear_busy_q <= 1'b1;
               end
            end
            ST_SWEEP: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_q      <= ST_IDLE;
                  clear_busy_q <= 1'b0;
                  clear_done_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               clear_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_hit     = rd_hit_q;
   assign rd_target  = rd_target_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_target_table.sv
`default_nettype none
// Testbench for pc_target_table: queue scoreboard on lookup results plus
// sweep busy/done accounting.
module tb_pc_target_table;

   localparam int D     = 12;
   localparam int A     = 5;
   localparam int BANKS = 2;
   localparam int BW    = 1;
   localparam int N     = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd_en;
   logic [BW-1:0] rd_bank;
   logic [A-1:0]  rd_addr;
   logic [D-1:0]  rd_pc;
   logic          rd_valid;
   logic          rd_hit;
   logic [D-1:0]  rd_target;
   logic          wr_en;
   logic [BW-1:0] wr_bank;
   logic [A-1:0]  wr_addr;
   logic          wr_rel;
   logic [D-1:0]  wr_data;
   logic          clear_req;
   logic [BW-1:0] clear_bank;
   logic          clear_busy;
   logic          clear_done;

   always #5 clk = ~clk;

   pc_target_table #(.D(D), .A(A), .BANKS(BANKS)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_en      (rd_en),
      .rd_bank    (rd_bank),
      .rd_addr    (rd_addr),
      .rd_pc      (rd_pc),
      .rd_valid   (rd_valid),
      .rd_hit     (rd_hit),
      .rd_target  (rd_target),
      .wr_en      (wr_en),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .wr_rel     (wr_rel),
      .wr_data    (wr_data),
      .clear_req  (clear_req),
      .clear_bank (clear_bank),
      .clear_busy (clear_busy),
      .clear_done (clear_done)
   );

   int           checks   = 0;
   int           errors   = 0;
   int           busy_cnt = 0;
   int           done_cnt = 0;
   logic [D+1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // One clock: queue the expected lookup result, advance, pop and compare.
   task automatic cyc(input logic eh, input logic [D-1:0] et);
      logic [D+1:0] e;
      exp_q.push_back({rd_en, eh, et});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("rd_valid", 32'(rd_valid), 32'(e[D+1]));
      chk("rd_hit", 32'(rd_hit), 32'(e[D]));
      chk("rd_target", 32'(rd_target), 32'(e[D-1:0]));
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
   endtask

   task automatic rd(input logic [BW-1:0] b, input logic [A-1:0] a, input logic [D-1:0] pc,
                     input logic eh, input logic [D-1:0] et);
      rd_en   = 1'b1;
      rd_bank = b;
      rd_addr = a;
      rd_pc   = pc;
      cyc(eh, et);
      rd_en   = 1'b0;
   endtask

   task automatic wr(input logic [BW-1:0] b, input logic [A-1:0] a, input logic rel,
                     input logic [D-1:0] data);
      wr_en   = 1'b1;
      wr_bank = b;
      wr_addr = a;
      wr_rel  = rel;
      wr_data = data;
      cyc(1'b0, '0);
      wr_en   = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      rd_en      = 1'b0;
      rd_bank    = '0;
      rd_addr    = '0;
      rd_pc      = '0;
      wr_en      = 1'b0;
      wr_bank    = '0;
      wr_addr    = '0;
      wr_rel     = 1'b0;
      wr_data    = '0;
      clear_req  = 1'b0;
      clear_bank = '0;
      cyc(1'b0, '0);
      cyc(1'b0, '0);
      reset = 1'b0;
      chk("busy_reset", 32'(clear_busy), 32'd0);
      chk("done_reset", 32'(clear_done), 32'd0);

      rd(1'b0, 5'd3, 12'd0, 1'b0, 12'd0);

      wr(1'b0, 5'd1, 1'b0, 12'd224);
      rd(1'b0, 5'd1, 12'd0, 1'b1, 12'd224);
      rd(1'b1, 5'd1, 12'd0, 1'b0, 12'd0);

      wr(1'b1, 5'd2, 1'b1, 12'hFFB);
      rd(1'b1, 5'd2, 12'd4, 1'b1, 12'hFFF);
      wr(1'b1, 5'd5, 1'b1, 12'd20);
      rd(1'b1, 5'd5, 12'hFF0, 1'b1, 12'h004);

      // Same-cycle write and read of one entry.
      wr_en   = 1'b1;
      wr_bank = 1'b0;
      wr_addr = 5'd7;
      wr_rel  = 1'b0;
      wr_data = 12'd107;
      rd_en   = 1'b1;
      rd_bank = 1'b0;
      rd_addr = 5'd7;
      rd_pc   = 12'h100;
      cyc(1'b1, 12'd107);
      wr_en = 1'b0;
      rd_en = 1'b0;
      rd(1'b0, 5'd7, 12'h100, 1'b1, 12'd107);

      for (int i = 0; i < N; i++) begin
         wr(1'b0, A'(i), 1'b0, D'(100 + i));
         wr(1'b1, A'(i), 1'b0, D'(500 + i));
      end
      rd(1'b0, 5'd31, 12'd0, 1'b1, 12'd131);
      rd(1'b1, 5'd0, 12'd0, 1'b1, 12'd500);

      busy_cnt   = 0;
      done_cnt   = 0;
      clear_req  = 1'b1;
      clear_bank = 1'b0;
      cyc(1'b0, '0);
      clear_req  = 1'b0;
      chk("busy_start", 32'(clear_busy), 32'd1);
      for (int i = 0; i < 40; i++) begin
         if (i == 5) begin
            wr(1'b0, 5'd3, 1'b0, 12'd77);
         end else if (i == 7) begin
            clear_req  = 1'b1;
            clear_bank = 1'b0;
            rd(1'b1, 5'd7, 12'd0, 1'b1, 12'd507);
            clear_req  = 1'b0;
         end else if (i % 2 == 1) begin
            rd(1'b0, A'(i % N), 12'd0, 1'b0, 12'd0);
         end else begin
            rd(1'b1, A'(i % N), 12'd0, 1'b1, D'(500 + (i % N)));
         end
      end
      chk("busy_cycles", 32'(busy_cnt), 32'd32);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("busy_end", 32'(clear_busy), 32'd0);
      for (int i = 0; i < N; i++) begin
         rd(1'b0, A'(i), 12'd0, 1'b0, 12'd0);
      end
      rd(1'b1, 5'd9, 12'd0, 1'b1, 12'd509);

      for (int i = 0; i < 4; i++) begin
         wr(1'b0, A'(i), 1'b1, D'(i));
      end
      clear_req  = 1'b1;
      clear_bank = 1'b1;
      cyc(1'b0, '0);
      clear_req  = 1'b0;
      repeat (9) cyc(1'b0, '0);
      chk("busy_mid", 32'(clear_busy), 32'd1);
      done_cnt = 0;
      reset    = 1'b1;
      cyc(1'b0, '0);
      reset    = 1'b0;
      chk("busy_abort", 32'(clear_busy), 32'd0);
      chk("done_abort", 32'(clear_done), 32'd0);
      repeat (40) cyc(1'b0, '0);
      chk("done_after_abort", 32'(done_cnt), 32'd0);
      for (int b = 0; b < BANKS; b++) begin
         for (int i = 0; i < N; i++) begin
            rd(BW'(b), A'(i), 12'd0, 1'b0, 12'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
